// File: rtl/char_buf_arbiter.sv
// char_buf_arbiter: 256x8 text-overlay character buffer with a round-robin, vblank-gated write arbiter.
// A clear sequencer fills the buffer with FILL_CHAR after reset and on clear_req.
module char_buf_arbiter #(
    parameter int          N_REQ     = 2,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblnk,
    input  logic [7:0]         char_xy,
    output logic [7:0]         char_code,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*8-1:0] req_addr,
    input  logic [N_REQ*8-1:0] req_char,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               clear_req,
    output logic               clear_busy
);
    typedef enum logic {S_CLEAR, S_IDLE} state_t;
    state_t      r_state, w_state_nx;
    logic [7:0]  r_clr_addr, w_clr_nx;
    logic [1:0]  r_rr_ptr, w_ptr_nx;
    logic [1:0]  w_gnt;
    logic [2:0]  w_idx;
    logic        w_any, w_wr, w_we;
    logic [7:0]  w_waddr, w_wdata;
    logic [7:0]  r_mem [256];
    logic [7:0]  r_char_code;
    // First valid requester at or after r_rr_ptr: scan offsets high to low so the smallest offset wins.
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + 3'(k);
            if (w_idx >= 3'(N_REQ)) w_idx = w_idx - 3'(N_REQ);
            for (int j = 0; j < N_REQ; j++) begin
                if (w_idx == 3'(j) && req_valid[j]) begin
                    w_gnt = 2'(j);
                    w_any = 1'b1;
                end
            end
        end
    end
    assign w_wr      = (r_state == S_IDLE) && !clear_req && vblnk && w_any;
    assign req_ready = w_wr ? N_REQ'(1) << w_gnt : '0;
    assign clear_busy = (r_state == S_CLEAR);
    always_comb begin
        w_waddr = r_clr_addr;
        w_wdata = FILL_CHAR;
        if (r_state == S_IDLE) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (w_gnt == 2'(k)) begin
                    w_waddr = req_addr[8*k +: 8];
                    w_wdata = req_char[8*k +: 8];
                end
            end
        end
    end
    // A write landing on the same edge as rst is dropped.
    assign w_we = !rst && (clear_busy || w_wr);
    always_comb begin
        w_state_nx = r_state;
        w_clr_nx   = r_clr_addr;
        w_ptr_nx   = r_rr_ptr;
        if (r_state == S_CLEAR) begin
            w_clr_nx = r_clr_addr + 8'd1;
            if (r_clr_addr == 8'hFF) w_state_nx = S_IDLE;
        end else if (clear_req) begin
            w_state_nx = S_CLEAR;
            w_clr_nx   = 8'd0;
        end else if (w_wr) begin
            w_ptr_nx = (w_gnt == 2'(N_REQ - 1)) ? 2'd0 : w_gnt + 2'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= 8'd0;
            r_rr_ptr   <= 2'd0;
        end else begin
            r_state    <= w_state_nx;
            r_clr_addr <= w_clr_nx;
            r_rr_ptr   <= w_ptr_nx;
        end
    end
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) r_char_code <= 8'd0;
        else     r_char_code <= r_mem[char_xy];
    end
    assign char_code = r_char_code;
endmodule

// File: tb/tb_char_buf_arbiter.sv
// tb_char_buf_arbiter: directed bench for char_buf_arbiter (N_REQ=2, FILL_CHAR=8'h20).
module tb_char_buf_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblnk = 1'b0;
    logic [7:0]  char_xy = '0;
    logic [7:0]  char_code;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_char = '0;
    logic [1:0]  req_ready;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_clr;
    logic [7:0]  n0, n1;
    logic [1:0]  exp_rdy;

    char_buf_arbiter #(.N_REQ(2), .FILL_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .char_xy(char_xy), .char_code(char_code),
        .req_valid(req_valid), .req_addr(req_addr), .req_char(req_char), .req_ready(req_ready),
        .clear_req(clear_req), .clear_busy(clear_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] e);
        char_xy = a;
        @(posedge clk);
        @(negedge clk);
        chk(tag, char_code, e);
    endtask

    // Counts negedges with clear_busy high, starting at the current one.
    task automatic measure(output int n);
        n = 0;
        while (clear_busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_code", char_code, 8'h00);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_busy", clear_busy, 1'b1);
        rst = 1'b0;
        measure(n_clr);
        chk("clr_len", n_clr, 256);
        for (int a = 0; a < 256; a++) rd("sweep", 8'(a), 8'h20);

        // Blank gating
        req_valid = 2'b01;
        req_addr  = 16'h0012;
        req_char  = 16'h0041;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("gate_off", req_ready, 2'b00);
        end
        vblnk = 1'b1;
        #1 chk("gate_on", req_ready, 2'b01);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk("gate_drop", req_ready, 2'b00);
        rd("gate_rd", 8'h12, 8'h41);

        // Round-robin: pointer is 1 after the last grant to req0
        n0 = 0;
        n1 = 0;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            req_addr = {8'h40 + n1, 8'h30 + n0};
            req_char = {8'h70 + n1, 8'h60 + n0};
            exp_rdy  = (i % 2 == 0) ? 2'b10 : 2'b01;
            #1 chk("rr_gnt", req_ready, exp_rdy);
            @(posedge clk);
            #1 if (exp_rdy[0]) n0++; else n1++;
            @(negedge clk);
        end
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            rd("rr_rd0", 8'h30 + 8'(i), 8'h60 + 8'(i));
            rd("rr_rd1", 8'h40 + 8'(i), 8'h70 + 8'(i));
        end

        // Clear collision: pointer is 1 again
        req_valid = 2'b10;
        req_addr  = 16'h5500;
        req_char  = 16'hAB00;
        clear_req = 1'b1;
        #1 chk("col_nogrant", req_ready, 2'b00);
        @(posedge clk);
        #1 clear_req = 1'b0;
        @(negedge clk);
        chk("col_busy", clear_busy, 1'b1);
        chk("col_ready", req_ready, 2'b00);
        measure(n_clr);
        chk("col_len", n_clr, 256);
        chk("col_after", req_ready, 2'b10);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        rd("col_rd", 8'h55, 8'hAB);

        // Read-during-write
        char_xy   = 8'h05;
        req_valid = 2'b01;
        req_addr  = 16'h0005;
        req_char  = 16'h0033;
        #1 chk("rdw_gnt", req_ready, 2'b01);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk("rdw_old", char_code, 8'h20);
        @(negedge clk);
        chk("rdw_new", char_code, 8'h33);

        // Reset mid-clear at clr_addr=100
        vblnk = 1'b0;
        clear_req = 1'b1;
        @(posedge clk);
        #1 clear_req = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy", clear_busy, 1'b1);
        chk("mid_code", char_code, 8'h00);
        rst = 1'b0;
        measure(n_clr);
        chk("mid_len", n_clr, 256);
        rd("mid_rd05", 8'h05, 8'h20);
        rd("mid_rd55", 8'h55, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/char_buf_arbiter.md
# char_buf_arbiter

Owns the 256-entry character buffer that feeds the text overlay's `char_xy` address port. Serves the renderer's read port every cycle with 1-cycle latency. Arbitrates single-character writes from `N_REQ` game-logic requesters (score, status, menu) round-robin, and applies them only while `vblnk` is high, so a frame never tears mid-line. A clear sequencer fills the buffer with `FILL_CHAR`, automatically after reset and on request.

## Interface
- `N_REQ`, 2: number of write requesters, 2..4.
- `FILL_CHAR`, 8'h20: code written by a clear.

- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `vblnk` in 1: vertical blank from the VGA timing chain; write window.
- `char_xy` in 8: read address from the draw block, `{row[3:0], col[3:0]}`.
- `char_code` out 8: buffer content at `char_xy`, registered.
- `req_valid` in N_REQ: per-requester write request.
- `req_addr` in N_REQ*8: packed addresses, requester i at `[8i+7:8i]`.
- `req_char` in N_REQ*8: packed character codes, same packing.
- `req_ready` out N_REQ: combinational grant; write accepted on the clock edge where `valid && ready`.
- `clear_req` in 1: single-cycle pulse; start a full-buffer clear.
- `clear_busy` out 1: high while a clear is in progress.

## Operation
- Storage: 256x8 dual-port RAM, inferable as block RAM. The read port is independent of the write port. Contents are not reset.
- The FSM has two states: CLEAR and IDLE.
- **CLEAR**
  - An 8-bit counter `clr_addr` starts at 0.
  - One `FILL_CHAR` is written per cycle at `clr_addr`, then `clr_addr` increments.
  - Writes ignore `vblnk`.
  - After writing address 255, the FSM goes to IDLE.
  - All `req_ready` bits are 0 in this state.
  - `clear_req` received during CLEAR is ignored and does not restart the counter.
- **IDLE**
  - If `clear_req` is high, enter CLEAR with `clr_addr`=0. No grant is issued that cycle, because clear has priority over requesters.
  - Else if `vblnk`=1 and any `req_valid` is set, grant exactly one requester. The grant goes to the first valid requester at or after pointer `rr_ptr`, searching upward modulo `N_REQ`. Its `req_char` is written at its `req_addr`, and `rr_ptr` becomes grant+1 mod `N_REQ`.
  - Else no write occurs and `rr_ptr` holds.
- `req_ready[i]` = IDLE && !`clear_req` && `vblnk` && grant==i. It is a function of the current inputs and state only.
- Requesters must hold `valid`, `addr` and `char` stable until `ready`. A dropped request is simply not written.
- **Read path**
  - `char_code` <= RAM[`char_xy`] each cycle, including during CLEAR.
  - A same-cycle read and write to the same address returns the old data (read-first).

## Timing
- **Reset**
  - Outputs: `char_code`=0, `req_ready`=0, `clear_busy`=1.
  - State: state=CLEAR, `clr_addr`=0, `rr_ptr`=0.
  - The post-reset clear runs 256 cycles. `clear_busy` falls in the cycle after address 255 is written.
- Reset asserted mid-clear or mid-write restarts the clear from address 0. A write on the same edge as `rst` is discarded.
- **Latencies**
  - Read: `char_xy` at edge n gives `char_code` valid after edge n+1, i.e. 1 cycle. The draw block accounts for this in its own delay line.
  - Write: data is visible on the read port one cycle after the accepting edge.
  - `clear_busy`: 1 in the cycle after the `clear_req` edge. Total clear duration is exactly 256 cycles.
- **Throughput**
  - One write per cycle during vblank.
  - Fairness: with all requesters continuously valid, each receives exactly one grant per `N_REQ` cycles.
- `vblnk` falling: no grant in that cycle. A pending request waits for the next vblank.

## Test plan
- **Reset and clear:** release `rst`, sweep `char_xy` 0..255 after `clear_busy` falls. Required: every `char_code`=8'h20, and `clear_busy` high for exactly 256 cycles.
- **Blank gating:** req0 valid, addr 8'h12, char 8'h41, `vblnk`=0 for 10 cycles, then 1. Required: `ready`=0 until `vblnk` rises; `ready` then high for one cycle; reading 8'h12 returns 8'h41.
- **Round-robin:** `N_REQ`=2, both valid continuously in vblank, each writing incrementing chars. Required: grant order 0,1,0,1…; no requester waits more than 1 cycle.
- **Clear collision:** `clear_req` and req1 valid in the same IDLE vblank cycle. Required: no grant; `clear_busy`=1 next cycle; req1 granted only after the clear; its char survives at its address.
- **Read-during-write:** `char_xy`=8'h05 while writing 8'h33 to 8'h05. Required: `char_code` shows the old value the next cycle and 8'h33 one cycle later.
- **Reset mid-clear:** assert `rst` at `clr_addr`=100. Required: the clear restarts at 0 and takes a full 256 cycles.
